// File: rtl/cook_sequencer_pkg.sv
// Shared types and constants for the microwave cook sequencer.
package cook_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENTRY = 2'd1,
    ST_COOK  = 2'd2,
    ST_PAUSE = 2'd3
  } state_e;

  typedef enum logic {
    EDGE_RISE = 1'b0,
    EDGE_FALL = 1'b1
  } edge_pol_e;

  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic is_bcd(input logic [3:0] d);
    return d <= BCD_MAX;
  endfunction

endpackage

// File: rtl/edge_det.sv
// Registered edge detector with a one-cycle output pulse; POL selects rising or falling edge.
module edge_det
  import cook_sequencer_pkg::*;
#(
  parameter edge_pol_e POL = EDGE_RISE
) (
  input  logic clock,
  input  logic clearn,
  input  logic sig,
  output logic pulse
);

  // History resets to the post-edge level so an input already asserted
  // when reset releases does not register as a fresh edge.
  localparam logic POST_LEVEL = (POL == EDGE_RISE);

  logic prev;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      prev  <= POST_LEVEL;
      pulse <= 1'b0;
    end else begin
      prev  <= sig;
      pulse <= (POL == EDGE_RISE) ? (sig & ~prev) : (~sig & prev);
    end
  end

endmodule

// File: rtl/cook_sequencer.sv
// Microwave front-panel sequencer: keypad entry, cook/pause/done control, timer strobes.
// Optional idle auto-clear in ENTRY is enabled by defining ENTRY_TIMEOUT_EN.
module cook_sequencer
  import cook_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 30000,
  parameter int TO_W           = 15
) (
  input  logic        clock,
  input  logic        clearn,
  input  logic [3:0]  digit,
  input  logic        loadn,
  input  logic        pgt,
  input  logic        start_n,
  input  logic        stop_n,
  input  logic        door_closed,
  input  logic        timer_zero,
  output logic        key_enable,
  output logic [15:0] entry,
  output logic        load_timer,
  output logic        count_en,
  output logic        done,
  output logic [1:0]  state
);

  state_e      cur_state, next_state;
  logic [15:0] next_entry;
  logic        next_load, next_done;
  logic        pgt_evt, start_evt, stop_evt;
  logic [3:0]  digit_q;
  logic        loadn_q;
  logic        key;
  logic        timeout;

  edge_det #(.POL(EDGE_RISE)) u_pgt_edge (
    .clock (clock), .clearn(clearn), .sig(pgt),     .pulse(pgt_evt)
  );
  edge_det #(.POL(EDGE_FALL)) u_start_edge (
    .clock (clock), .clearn(clearn), .sig(start_n), .pulse(start_evt)
  );
  edge_det #(.POL(EDGE_FALL)) u_stop_edge (
    .clock (clock), .clearn(clearn), .sig(stop_n),  .pulse(stop_evt)
  );

  // Digit and loadn are delayed one cycle to line up with the registered pgt pulse.
  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      digit_q <= 4'd0;
      loadn_q <= 1'b1;
    end else begin
      digit_q <= digit;
      loadn_q <= loadn;
    end
  end

  assign key = pgt_evt & ~loadn_q & is_bcd(digit_q);

`ifdef ENTRY_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;

  assign timeout = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      to_cnt <= '0;
    end else if (cur_state != ST_ENTRY || key) begin
      to_cnt <= '0;
    end else if (!timeout) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    next_state = cur_state;
    next_entry = entry;
    next_load  = 1'b0;
    next_done  = 1'b0;
    case (cur_state)
      ST_IDLE: begin
        if (key) begin
          next_entry = {12'h000, digit_q};
          next_state = ST_ENTRY;
        end
      end
      ST_ENTRY: begin
        if (stop_evt) begin
          next_entry = 16'h0000;
          next_state = ST_IDLE;
        end else if (start_evt && door_closed && entry != 16'h0000) begin
          next_load  = 1'b1;
          next_state = ST_COOK;
        end else if (timeout) begin
          next_entry = 16'h0000;
          next_state = ST_IDLE;
        end else if (key) begin
          next_entry = {entry[11:0], digit_q};
        end
      end
      ST_COOK: begin
        if (timer_zero) begin
          next_done  = 1'b1;
          next_entry = 16'h0000;
          next_state = ST_IDLE;
        end else if (stop_evt || !door_closed) begin
          next_state = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (stop_evt) begin
          next_entry = 16'h0000;
          next_state = ST_IDLE;
        end else if (start_evt && door_closed) begin
          next_state = ST_COOK;
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // NOTE: the entry register is a handful of flops feeding the timer, not a
  // memory array, so it is reset along with the rest of the state.
  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      cur_state  <= ST_IDLE;
      entry      <= 16'h0000;
      load_timer <= 1'b0;
      done       <= 1'b0;
    end else begin
      cur_state  <= next_state;
      entry      <= next_entry;
      load_timer <= next_load;
      done       <= next_done;
    end
  end

  // Decoded from state so that reset and door opening both remove count enable at once.
  assign count_en   = (cur_state == ST_COOK) && door_closed;
  assign key_enable = (cur_state == ST_IDLE) || (cur_state == ST_ENTRY);
  assign state      = cur_state;

endmodule

// File: tb/tb_cook_sequencer.sv
// Directed self-checking bench for cook_sequencer; inputs change and outputs are sampled on negedge.
module tb_cook_sequencer;

  logic        clock;
  logic        clearn;
  logic [3:0]  digit;
  logic        loadn;
  logic        pgt;
  logic        start_n;
  logic        stop_n;
  logic        door_closed;
  logic        timer_zero;
  logic        key_enable;
  logic [15:0] entry;
  logic        load_timer;
  logic        count_en;
  logic        done;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  cook_sequencer #(.TIMEOUT_CYCLES(20), .TO_W(15)) dut (
    .clock      (clock),
    .clearn     (clearn),
    .digit      (digit),
    .loadn      (loadn),
    .pgt        (pgt),
    .start_n    (start_n),
    .stop_n     (stop_n),
    .door_closed(door_closed),
    .timer_zero (timer_zero),
    .key_enable (key_enable),
    .entry      (entry),
    .load_timer (load_timer),
    .count_en   (count_en),
    .done       (done),
    .state      (state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [3:0] d);
    digit = d;
    loadn = 1'b0;
    pgt   = 1'b1;
    tick(1);
    pgt   = 1'b0;
    loadn = 1'b1;
    tick(2);
  endtask

  initial begin
    clearn      = 1'b0;
    digit       = 4'd0;
    loadn       = 1'b1;
    pgt         = 1'b0;
    start_n     = 1'b1;
    stop_n      = 1'b1;
    door_closed = 1'b1;
    timer_zero  = 1'b0;
    tick(2);

    check("rst_state", 16'(state), 16'd0);
    check("rst_entry", entry, 16'h0000);
    check("rst_key_enable", 16'(key_enable), 16'd1);
    check("rst_load", 16'(load_timer), 16'd0);
    check("rst_count_en", 16'(count_en), 16'd0);
    check("rst_done", 16'(done), 16'd0);
    clearn = 1'b1;
    tick(2);

    // Keys 1,3,0 then start with the door closed.
    press(4'd1);
    check("first_key_state", 16'(state), 16'd1);
    check("first_key_entry", entry, 16'h0001);
    press(4'd3);
    press(4'd0);
    check("entry_130", entry, 16'h0130);
    start_n = 1'b0;
    tick(2);
    check("start_load", 16'(load_timer), 16'd1);
    check("start_state", 16'(state), 16'd2);
    check("start_count_en", 16'(count_en), 16'd1);
    check("start_key_enable", 16'(key_enable), 16'd0);
    start_n = 1'b1;
    tick(1);
    check("load_one_cycle", 16'(load_timer), 16'd0);

    press(4'd5);
    check("cook_key_ignored", entry, 16'h0130);

    // Door opens mid-cook, then closes and restarts without reload.
    door_closed = 1'b0;
    tick(1);
    check("door_open_state", 16'(state), 16'd3);
    check("door_open_count_en", 16'(count_en), 16'd0);
    door_closed = 1'b1;
    tick(1);
    check("pause_closed_state", 16'(state), 16'd3);
    check("pause_closed_count_en", 16'(count_en), 16'd0);
    start_n = 1'b0;
    tick(2);
    check("resume_state", 16'(state), 16'd2);
    check("resume_no_load", 16'(load_timer), 16'd0);
    check("resume_count_en", 16'(count_en), 16'd1);
    start_n = 1'b1;
    tick(1);

    // Completion.
    timer_zero = 1'b1;
    tick(1);
    check("done_pulse", 16'(done), 16'd1);
    check("done_entry", entry, 16'h0000);
    check("done_state", 16'(state), 16'd0);
    check("done_key_enable", 16'(key_enable), 16'd1);
    timer_zero = 1'b0;
    tick(1);
    check("done_one_cycle", 16'(done), 16'd0);

    // Five digits drop the oldest; non-BCD and loadn-high strobes ignored.
    press(4'd1);
    press(4'd2);
    press(4'd3);
    press(4'd4);
    press(4'd5);
    check("entry_2345", entry, 16'h2345);
    press(4'hA);
    check("digit_a_ignored", entry, 16'h2345);
    digit = 4'd6;
    pgt   = 1'b1;
    tick(1);
    pgt   = 1'b0;
    tick(2);
    check("loadn_high_ignored", entry, 16'h2345);

    // Start and stop fall together: stop wins.
    start_n = 1'b0;
    stop_n  = 1'b0;
    tick(2);
    check("start_stop_state", 16'(state), 16'd0);
    check("start_stop_entry", entry, 16'h0000);
    check("start_stop_no_load", 16'(load_timer), 16'd0);
    start_n = 1'b1;
    stop_n  = 1'b1;
    tick(1);

    // Start ignored with door open, and with an all-zero entry.
    press(4'd7);
    door_closed = 1'b0;
    start_n = 1'b0;
    tick(2);
    check("door_open_start_state", 16'(state), 16'd1);
    check("door_open_start_load", 16'(load_timer), 16'd0);
    start_n = 1'b1;
    tick(1);
    door_closed = 1'b1;
    stop_n = 1'b0;
    tick(2);
    check("entry_stop_state", 16'(state), 16'd0);
    check("entry_stop_entry", entry, 16'h0000);
    stop_n = 1'b1;
    tick(1);
    press(4'd0);
    check("zero_entry_state", 16'(state), 16'd1);
    start_n = 1'b0;
    tick(2);
    check("zero_start_state", 16'(state), 16'd1);
    check("zero_start_load", 16'(load_timer), 16'd0);
    start_n = 1'b1;
    stop_n  = 1'b0;
    tick(2);
    stop_n  = 1'b1;
    tick(1);

    // Asynchronous reset mid-cook.
    press(4'd2);
    start_n = 1'b0;
    tick(2);
    start_n = 1'b1;
    tick(1);
    check("pre_reset_count_en", 16'(count_en), 16'd1);
    clearn = 1'b0;
    #1;
    check("async_rst_state", 16'(state), 16'd0);
    check("async_rst_count_en", 16'(count_en), 16'd0);
    check("async_rst_key_enable", 16'(key_enable), 16'd1);
    check("async_rst_entry", entry, 16'h0000);
    check("async_rst_load", 16'(load_timer), 16'd0);
    check("async_rst_done", 16'(done), 16'd0);
    tick(1);
    clearn = 1'b1;
    tick(2);

`ifdef ENTRY_TIMEOUT_EN
    press(4'd7);
    tick(10);
    check("timeout_not_yet", 16'(state), 16'd1);
    tick(15);
    check("timeout_state", 16'(state), 16'd0);
    check("timeout_entry", entry, 16'h0000);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
